// File: rtl/input_port_ctrl.sv
// Input-port controller for the wormhole router.
// Reads the flit at the input buffer head and computes the XY route for each
// head flit. It requests the switch allocator until the packet's tail flit has
// been popped, and forwards the popped flits on a registered output toward the
// crossbar.
// Optional feature: define IPC_ERR_CNT_EN to add err_cnt_o. This is a
// saturating 8-bit count of orphan BODY/TAIL flits that were popped and dropped
// while no packet was open.
module input_port_ctrl #(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int COORD_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] buf_flit_i,
  input  logic        buf_empty_i,
  output logic        buf_pop_o,
  output logic [4:0]  req_o,
  input  logic        grant_i,
  input  logic        out_ready_i,
  output logic [63:0] flit_o,
  output logic        flit_valid_o
`ifdef IPC_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt_o
`endif
);

  // One-hot request encoding, bit order {LOCAL,WEST,SOUTH,EAST,NORTH}
  localparam logic [4:0] ReqNorth = 5'b00001;
  localparam logic [4:0] ReqEast  = 5'b00010;
  localparam logic [4:0] ReqSouth = 5'b00100;
  localparam logic [4:0] ReqWest  = 5'b01000;
  localparam logic [4:0] ReqLocal = 5'b10000;

  localparam logic [COORD_W-1:0] XC = COORD_W'(X_COORD);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y_COORD);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACTIVE
  } state_e;

  state_e             state_q;
  logic [4:0]         route_q;
  logic [63:0]        flit_q;
  logic               valid_q;

  logic [4:0]         route_d;
  logic               pop_d;
  logic [COORD_W-1:0] destX;
  logic [COORD_W-1:0] destY;
  logic               isHead;
  logic               isLast;

  // Type bit 62 marks HEAD/HEADTAIL; type bit 63 marks TAIL/HEADTAIL
  assign isHead = buf_flit_i[62];
  assign isLast = buf_flit_i[63];
  assign destX  = buf_flit_i[61 -: COORD_W];
  assign destY  = buf_flit_i[61-COORD_W -: COORD_W];

  // XY dimension-order route of the flit at the buffer head: resolve X first, then Y
  always_comb begin
    route_d = ReqLocal;
    if (destX > XC) begin
      route_d = ReqEast;
    end else if (destX < XC) begin
      route_d = ReqWest;
    end else if (destY > YC) begin
      route_d = ReqNorth;
    end else if (destY < YC) begin
      route_d = ReqSouth;
    end
  end

  // Pop orphans immediately in IDLE; in ACTIVE pop only when data and downstream credit exist.
  // Reset masks the pop so an orphan sitting at the head is not consumed during reset.
  always_comb begin
    pop_d = 1'b0;
    if (rst_n && !buf_empty_i) begin
      if (state_q == IDLE) begin
        pop_d = !isHead;
      end else if (state_q == ACTIVE) begin
        pop_d = out_ready_i;
      end
    end
  end

  // Packet FSM: latch the route on a head, wait for grant, then stream flits until the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!buf_empty_i && isHead) begin
            route_q <= route_d;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (grant_i) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop_d) begin
            flit_q  <= buf_flit_i;
            valid_q <= 1'b1;
            if (isLast) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign buf_pop_o    = pop_d;
  assign req_o        = (state_q == IDLE) ? 5'b00000 : route_q;
  assign flit_o       = flit_q;
  assign flit_valid_o = valid_q;

`ifdef IPC_ERR_CNT_EN
  logic [7:0] errCnt_q;

  // Count orphan flits dropped in IDLE, sticking at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt_q <= 8'd0;
    end else if (pop_d && (state_q == IDLE) && (errCnt_q != 8'hFF)) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign err_cnt_o = errCnt_q;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl (X=1, Y=1).
// The bench models the input buffer as a queue. A scoreboard holds every
// expected forwarded flit and the route that must be held with it.
// Connects err_cnt_o when IDLE_ERR_CNT_EN-style macro IPC_ERR_CNT_EN is defined.
module tb_input_port_ctrl;

  localparam int XC = 1;
  localparam int YC = 1;
  localparam int CW = 4;

  logic        clk;
  logic        rstN;
  logic [63:0] bufFlit;
  logic        bufEmpty;
  logic        bufPop;
  logic [4:0]  req;
  logic        grant;
  logic        outReady;
  logic [63:0] flitOut;
  logic        flitValid;
`ifdef IPC_ERR_CNT_EN
  logic [7:0]  errCnt;
`endif

  int assertCnt = 0;
  int failCnt   = 0;
  int orphanCnt = 0;

  logic [63:0] bufQ[$];
  logic [63:0] expFlits[$];
  logic [4:0]  expRoute[$];

  logic stallEmpty = 1'b0;
  logic randomMode = 1'b0;
  logic autoGrant  = 1'b0;
  logic prevPop    = 1'b0;

  input_port_ctrl #(
    .X_COORD(XC),
    .Y_COORD(YC),
    .COORD_W(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .buf_flit_i  (bufFlit),
    .buf_empty_i (bufEmpty),
    .buf_pop_o   (bufPop),
    .req_o       (req),
    .grant_i     (grant),
    .out_ready_i (outReady),
    .flit_o      (flitOut),
    .flit_valid_o(flitValid)
`ifdef IPC_ERR_CNT_EN
    ,
    .err_cnt_o   (errCnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never drains
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference XY route computed directly from the coordinate comparison rules
  function automatic logic [4:0] xyRoute(input int dx, input int dy);
    if (dx > XC) return 5'b00010;
    if (dx < XC) return 5'b01000;
    if (dy > YC) return 5'b00001;
    if (dy < YC) return 5'b00100;
    return 5'b10000;
  endfunction

  function automatic logic [63:0] mkFlit(input logic [1:0] typ, input int dx, input int dy);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (typ[0]) return {typ, 4'(dx), 4'(dy), r[53:0]};
    return {typ, r[61:0]};
  endfunction

  task automatic driveBuf();
    bufEmpty = (bufQ.size() == 0) || stallEmpty;
    bufFlit  = (bufQ.size() != 0) ? bufQ[0] : 64'h0;
  endtask

  task automatic pushPacket(input int dx, input int dy, input int len);
    logic [4:0]  r;
    logic [63:0] f;
    r = xyRoute(dx, dy);
    for (int i = 0; i < len; i++) begin
      if (len == 1)          f = mkFlit(2'b11, dx, dy);
      else if (i == 0)       f = mkFlit(2'b01, dx, dy);
      else if (i == len - 1) f = mkFlit(2'b10, 0, 0);
      else                   f = mkFlit(2'b00, 0, 0);
      bufQ.push_back(f);
      expFlits.push_back(f);
      expRoute.push_back(r);
    end
  endtask

  task automatic pushOrphan(input logic asTail);
    bufQ.push_back(mkFlit(asTail ? 2'b10 : 2'b00, 0, 0));
    orphanCnt++;
  endtask

  // One clock cycle: check outputs at the falling edge, then update the buffer and inputs
  task automatic applyStimulus();
    logic        popNow;
    logic [63:0] expF;
    logic [4:0]  expR;
    @(negedge clk);
    if (bufEmpty) checkOutput("popWhileEmpty", 64'(bufPop), 64'd0);
    if (!prevPop) checkOutput("validWithoutPop", 64'(flitValid), 64'd0);
    if (flitValid) begin
      if (expFlits.size() != 0) begin
        expF = expFlits.pop_front();
        expR = expRoute.pop_front();
      end else begin
        expF = 64'hBADBADBADBADBAD0;
        expR = 5'h1F;
      end
      checkOutput("flitData", flitOut, expF);
      if (expF[63]) checkOutput("reqAfterTail", 64'(req), 64'd0);
      else          checkOutput("reqHeld", 64'(req), 64'(expR));
    end
    popNow  = bufPop;
    prevPop = popNow;
    @(posedge clk);
    #1;
    if (popNow && bufQ.size() != 0) void'(bufQ.pop_front());
    if (randomMode) begin
      stallEmpty = ($urandom_range(0, 4) == 0);
      outReady   = ($urandom_range(0, 3) != 0);
    end
    if (req == 5'd0) grant = 1'b0;
    else if (autoGrant && $urandom_range(0, 1) == 1) grant = 1'b1;
    driveBuf();
    #1;
  endtask

  task automatic runUntilDrained(input int budget);
    int n = 0;
    while ((expFlits.size() != 0 || bufQ.size() != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", 64'(expFlits.size() + bufQ.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] coordSel[4];
    int expErr;
    coordSel[0] = 4'd0;
    coordSel[1] = 4'd1;
    coordSel[2] = 4'd2;
    coordSel[3] = 4'd15;

    rstN     = 1'b0;
    grant    = 1'b0;
    outReady = 1'b1;
    pushOrphan(1'b0);
    driveBuf();
    #23;
    $display("[TB] reset state");
    checkOutput("resetReq", 64'(req), 64'd0);
    checkOutput("resetPop", 64'(bufPop), 64'd0);
    checkOutput("resetValid", 64'(flitValid), 64'd0);
    checkOutput("resetFlit", flitOut, 64'd0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1;
    prevPop = 1'b0;
    runUntilDrained(20);

    $display("[TB] test 1: head to (3,1) plus two bodies and a tail");
    pushPacket(3, 1, 4);
    driveBuf();
    #1;
    checkOutput("t1HeadNotPopped", 64'(bufPop), 64'd0);
    checkOutput("t1IdleReq", 64'(req), 64'd0);
    applyStimulus();
    checkOutput("t1Req1", 64'(req), 64'b00010);
    applyStimulus();
    checkOutput("t1Req2", 64'(req), 64'b00010);
    grant = 1'b1;
    applyStimulus();
    checkOutput("t1ActivePop", 64'(bufPop), 64'd1);
    runUntilDrained(50);
    checkOutput("t1ReqCleared", 64'(req), 64'd0);
    checkOutput("t1NoExtraValid", 64'(flitValid), 64'd0);

    $display("[TB] test 2: single-flit packet to the local port");
    pushPacket(1, 1, 1);
    driveBuf();
    #1;
    checkOutput("t2IdleReq", 64'(req), 64'd0);
    applyStimulus();
    checkOutput("t2Req", 64'(req), 64'b10000);
    grant = 1'b1;
    applyStimulus();
    checkOutput("t2Pop", 64'(bufPop), 64'd1);
    runUntilDrained(50);
    checkOutput("t2ReqCleared", 64'(req), 64'd0);

    $display("[TB] test 3: credit and empty stalls mid-packet");
    pushPacket(0, 1, 5);
    driveBuf();
    #1;
    applyStimulus();
    checkOutput("t3Req", 64'(req), 64'b01000);
    grant = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      outReady = 1'b0;
      driveBuf();
      #1;
      checkOutput("t3CreditStallPop", 64'(bufPop), 64'd0);
      checkOutput("t3CreditStallReq", 64'(req), 64'b01000);
      applyStimulus();
      checkOutput("t3CreditStallValid", 64'(flitValid), 64'd0);
    end
    outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stallEmpty = 1'b1;
      driveBuf();
      #1;
      checkOutput("t3EmptyStallPop", 64'(bufPop), 64'd0);
      checkOutput("t3EmptyStallReq", 64'(req), 64'b01000);
      applyStimulus();
      checkOutput("t3EmptyStallValid", 64'(flitValid), 64'd0);
    end
    stallEmpty = 1'b0;
    driveBuf();
    runUntilDrained(50);

    $display("[TB] test 4: orphan flits in IDLE");
    pushOrphan(1'b0);
    driveBuf();
    #1;
    checkOutput("t4OrphanPop", 64'(bufPop), 64'd1);
    applyStimulus();
    checkOutput("t4OrphanDropped", 64'(flitValid), 64'd0);
`ifdef IPC_ERR_CNT_EN
    checkOutput("t4ErrCnt1", 64'(errCnt), 64'(orphanCnt < 255 ? orphanCnt : 255));
`endif
    for (int i = 0; i < 256; i++) pushOrphan(i[0]);
    driveBuf();
    runUntilDrained(400);
`ifdef IPC_ERR_CNT_EN
    checkOutput("t4ErrCntSat", 64'(errCnt), 64'd255);
`endif

    $display("[TB] test 5: asynchronous reset mid-packet");
    pushPacket(1, 0, 5);
    driveBuf();
    #1;
    applyStimulus();
    checkOutput("t5Req", 64'(req), 64'b00100);
    grant = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    applyStimulus();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t5RstReq", 64'(req), 64'd0);
    checkOutput("t5RstPop", 64'(bufPop), 64'd0);
    checkOutput("t5RstValid", 64'(flitValid), 64'd0);
    checkOutput("t5RstFlit", flitOut, 64'd0);
`ifdef IPC_ERR_CNT_EN
    checkOutput("t5RstErrCnt", 64'(errCnt), 64'd0);
`endif
    bufQ.delete();
    expFlits.delete();
    expRoute.delete();
    orphanCnt = 0;
    grant = 1'b0;
    driveBuf();
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1;
    prevPop = 1'b0;
    pushPacket(1, 2, 3);
    driveBuf();
    #1;
    applyStimulus();
    checkOutput("t5PostRstReq", 64'(req), 64'b00001);
    grant = 1'b1;
    runUntilDrained(50);

    $display("[TB] test 6: back-to-back packets");
    pushPacket(0, 0, 3);
    pushPacket(2, 0, 2);
    driveBuf();
    #1;
    applyStimulus();
    grant = 1'b1;
    for (int n = 0; n < 50 && expFlits.size() > 2; n++) applyStimulus();
    checkOutput("t6NextHeadReq", 64'(req), 64'b00010);
    checkOutput("t6NextHeadPop", 64'(bufPop), 64'd0);
    grant = 1'b1;
    runUntilDrained(50);

    $display("[TB] random traffic");
    randomMode = 1'b1;
    autoGrant  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) pushOrphan(1'($urandom_range(0, 1)));
      pushPacket(int'(coordSel[$urandom_range(0, 3)]), int'(coordSel[$urandom_range(0, 3)]),
                 $urandom_range(1, 5));
    end
    driveBuf();
    runUntilDrained(4000);
    randomMode = 1'b0;
    stallEmpty = 1'b0;
    outReady   = 1'b1;
    driveBuf();
    applyStimulus();
`ifdef IPC_ERR_CNT_EN
    expErr = (orphanCnt < 255) ? orphanCnt : 255;
    checkOutput("errCntFinal", 64'(errCnt), 64'(expErr));
`else
    expErr = 0;
`endif
    checkOutput("finalIdleReq", 64'(req) + 64'(expErr - expErr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
